namuru_frontend: RTL and testbench

Front-end sample conditioner that sits directly upstream of the namuru baseband correlator bank. It synchronizes the raw 2-bit (sign/magnitude) RF front-end outputs into the sys_clk domain and delivers one registered sample per sample strobe to the correlators. Over a programmable window it also counts magnitude and sign statistics, which the CPU uses for front-end AGC and DC-bias monitoring.

---
 rtl/namuru_frontend.sv | 142 ++++++++++++++
 tb/tb_namuru_frontend.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/namuru_frontend.sv
// Front-end sample conditioner: synchronizes the 2-bit RF sign/magnitude pins, registers one
// sample per strobe, and gathers windowed magnitude/sign statistics with AGC threshold flags.
// Optional build macro NAMURU_FE_TESTGEN_EN adds a test_en port and an LFSR test-pattern source.
module namuru_frontend #(
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             gps_rec_sign,
  input  logic             gps_rec_mag,
  input  logic             sample_en,
`ifdef NAMURU_FE_TESTGEN_EN
  input  logic             test_en,
`endif
  input  logic [WIN_W-1:0] cfg_window,
  input  logic [WIN_W-1:0] cfg_agc_hi,
  input  logic [WIN_W-1:0] cfg_agc_lo,
  output logic             sample_sign,
  output logic             sample_mag,
  output logic             sample_valid,
  output logic [WIN_W-1:0] mag_count,
  output logic [WIN_W-1:0] sign_count,
  output logic             stats_ready,
  output logic             agc_high,
  output logic             agc_low
);

  localparam logic [WIN_W-1:0] ONE_W = {{(WIN_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sign_sync;
  logic [SYNC_STAGES-1:0] mag_sync;
  logic                   sel_sign;
  logic                   sel_mag;

  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_len;
  logic [WIN_W-1:0] mag_acc;
  logic [WIN_W-1:0] sign_acc;
  logic [WIN_W-1:0] cur_len;
  logic [WIN_W-1:0] mag_next;
  logic [WIN_W-1:0] sign_next;
  logic             win_active;
  logic             win_end;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sign_sync <= '0;
      mag_sync  <= '0;
    end else begin
      sign_sync <= {sign_sync[SYNC_STAGES-2:0], gps_rec_sign};
      mag_sync  <= {mag_sync[SYNC_STAGES-2:0], gps_rec_mag};
    end
  end

`ifdef NAMURU_FE_TESTGEN_EN
  logic [14:0] lfsr;
  logic        test_en_q;
  logic        test_sel;

  // The registered test_en takes its new value at the strobe it governs.
  assign test_sel = sample_en ? test_en : test_en_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lfsr      <= 15'h0001;
      test_en_q <= 1'b0;
    end else if (sample_en) begin
      lfsr      <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
      test_en_q <= test_en;
    end
  end

  always_comb begin
    sel_sign = sign_sync[SYNC_STAGES-1];
    sel_mag  = mag_sync[SYNC_STAGES-1];
    if (test_sel) begin
      sel_sign = lfsr[0];
      sel_mag  = lfsr[1];
    end
  end
`else
  always_comb begin
    sel_sign = sign_sync[SYNC_STAGES-1];
    sel_mag  = mag_sync[SYNC_STAGES-1];
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sample_sign  <= 1'b0;
      sample_mag   <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_en;
      if (sample_en) begin
        sample_sign <= sel_sign;
        sample_mag  <= sel_mag;
      end
    end
  end

  // At a window start the shadow length is being loaded, so use cfg_window directly.
  always_comb begin
    cur_len    = (win_cnt == '0) ? cfg_window : win_len;
    win_active = sample_en && (cur_len != '0);
    win_end    = win_active && (win_cnt == cur_len - ONE_W);
    mag_next   = mag_acc + (sel_mag ? ONE_W : '0);
    sign_next  = sign_acc + (sel_sign ? ONE_W : '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      win_cnt     <= '0;
      win_len     <= '0;
      mag_acc     <= '0;
      sign_acc    <= '0;
      mag_count   <= '0;
      sign_count  <= '0;
      stats_ready <= 1'b0;
      agc_high    <= 1'b0;
      agc_low     <= 1'b0;
    end else begin
      stats_ready <= win_end;
      if (sample_en && (win_cnt == '0)) win_len <= cfg_window;
      if (win_end) begin
        mag_count  <= mag_next;
        sign_count <= sign_next;
        agc_high   <= mag_next > cfg_agc_hi;
        agc_low    <= mag_next < cfg_agc_lo;
        win_cnt    <= '0;
        mag_acc    <= '0;
        sign_acc   <= '0;
      end else if (win_active) begin
        win_cnt  <= win_cnt + ONE_W;
        mag_acc  <= mag_next;
        sign_acc <= sign_next;
      end
    end
  end

endmodule

// File: tb/tb_namuru_frontend.sv
// Directed-vector bench for namuru_frontend: reset, sample path latency, windowed statistics,
// AGC flags, window-length changes, disabled statistics and mid-window reset.
module tb_namuru_frontend;

  localparam int WIN_W = 16;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             gps_rec_sign;
  logic             gps_rec_mag;
  logic             sample_en;
  logic [WIN_W-1:0] cfg_window;
  logic [WIN_W-1:0] cfg_agc_hi;
  logic [WIN_W-1:0] cfg_agc_lo;
  logic             sample_sign;
  logic             sample_mag;
  logic             sample_valid;
  logic [WIN_W-1:0] mag_count;
  logic [WIN_W-1:0] sign_count;
  logic             stats_ready;
  logic             agc_high;
  logic             agc_low;
`ifdef NAMURU_FE_TESTGEN_EN
  logic             test_en;
`endif

  int vectors = 0;
  int miscompares = 0;

  namuru_frontend #(.WIN_W(WIN_W), .SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .gps_rec_sign (gps_rec_sign),
    .gps_rec_mag  (gps_rec_mag),
    .sample_en    (sample_en),
`ifdef NAMURU_FE_TESTGEN_EN
    .test_en      (test_en),
`endif
    .cfg_window   (cfg_window),
    .cfg_agc_hi   (cfg_agc_hi),
    .cfg_agc_lo   (cfg_agc_lo),
    .sample_sign  (sample_sign),
    .sample_mag   (sample_mag),
    .sample_valid (sample_valid),
    .mag_count    (mag_count),
    .sign_count   (sign_count),
    .stats_ready  (stats_ready),
    .agc_high     (agc_high),
    .agc_low      (agc_low)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change 1 ns after the rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present a pin pair, let it cross the synchronizer, then strobe once.
  task automatic feed_sample(input logic s, input logic m);
    gps_rec_sign = s;
    gps_rec_mag  = m;
    sample_en    = 1'b0;
    tick();
    tick();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIN_W*2+6-1:0] got;
    apply_reset();
    got = {sample_sign, sample_mag, sample_valid, mag_count, sign_count, stats_ready, agc_high, agc_low};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h expected=0", got);
    end
  endtask

  task automatic test_single_sample();
    feed_sample(1'b1, 1'b0);
    vectors++;
    if ({sample_valid, sample_sign, sample_mag} !== 3'b110) begin
      miscompares++;
      $display("FAIL single_sample got v/s/m=%b%b%b expected 110", sample_valid, sample_sign, sample_mag);
    end
    vectors++;
    if ({stats_ready, mag_count, sign_count, agc_high, agc_low} !== '0) begin
      miscompares++;
      $display("FAIL single_sample_stats got rdy=%b mag=%0d sign=%0d hi=%b lo=%b expected all 0",
               stats_ready, mag_count, sign_count, agc_high, agc_low);
    end
    tick();
    vectors++;
    if ({sample_valid, sample_sign} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_sample_hold got valid=%b sign=%b expected valid=0 sign=1", sample_valid, sample_sign);
    end
  endtask

  task automatic test_latency();
    gps_rec_sign = 1'b0;
    gps_rec_mag  = 1'b0;
    sample_en    = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    gps_rec_sign = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (sample_sign !== (i >= 3) || sample_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL latency cycle %0d got sign=%b valid=%b expected sign=%b valid=1",
                 i, sample_sign, sample_valid, (i >= 3));
      end
    end
    sample_en = 1'b0;
    tick();
  endtask

  // Feed one window (bit i of the patterns is sample i) and check stats_ready only on the last.
  task automatic run_window(input logic [15:0] mags, input logic [15:0] signs, input int n,
                            input string name);
    for (int i = 0; i < n; i++) begin
      feed_sample(signs[i], mags[i]);
      vectors++;
      if (stats_ready !== (i == n - 1)) begin
        miscompares++;
        $display("FAIL %s ready at sample %0d got=%b expected=%b", name, i, stats_ready, (i == n - 1));
      end
    end
  endtask

  task automatic test_stats_agc();
    cfg_window = 16'd8;
    cfg_agc_hi = 16'd3;
    cfg_agc_lo = 16'd1;
    run_window(16'b1000_1011, 16'hFFFF, 8, "stats_win1");
    vectors++;
    if (mag_count !== 16'd4 || sign_count !== 16'd8) begin
      miscompares++;
      $display("FAIL stats_win1_counts got mag=%0d sign=%0d expected mag=4 sign=8", mag_count, sign_count);
    end
    vectors++;
    if ({agc_high, agc_low} !== 2'b10) begin
      miscompares++;
      $display("FAIL agc_win1 got hi=%b lo=%b expected hi=1 lo=0", agc_high, agc_low);
    end
    tick();
    vectors++;
    if (stats_ready !== 1'b0 || mag_count !== 16'd4) begin
      miscompares++;
      $display("FAIL stats_pulse_width got rdy=%b mag=%0d expected rdy=0 mag=4", stats_ready, mag_count);
    end
    run_window(16'h0000, 16'b1010_1010, 8, "stats_win2");
    vectors++;
    if (mag_count !== 16'd0 || sign_count !== 16'd4 || {agc_high, agc_low} !== 2'b01) begin
      miscompares++;
      $display("FAIL stats_win2 got mag=%0d sign=%0d hi=%b lo=%b expected mag=0 sign=4 hi=0 lo=1",
               mag_count, sign_count, agc_high, agc_low);
    end
  endtask

  task automatic test_window_change();
    cfg_window = 16'd8;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) cfg_window = 16'd4;
      feed_sample(1'b0, 1'b1);
      vectors++;
      if (stats_ready !== (i == 7)) begin
        miscompares++;
        $display("FAIL win_change_long ready at sample %0d got=%b expected=%b", i, stats_ready, (i == 7));
      end
    end
    vectors++;
    if (mag_count !== 16'd8 || sign_count !== 16'd0) begin
      miscompares++;
      $display("FAIL win_change_long_counts got mag=%0d sign=%0d expected mag=8 sign=0", mag_count, sign_count);
    end
    run_window(16'h000F, 16'h0000, 4, "win_change_short1");
    run_window(16'h000F, 16'h0005, 4, "win_change_short2");
    vectors++;
    if (mag_count !== 16'd4 || sign_count !== 16'd2) begin
      miscompares++;
      $display("FAIL win_change_short_counts got mag=%0d sign=%0d expected mag=4 sign=2", mag_count, sign_count);
    end
  endtask

  task automatic test_disabled();
    int ready_seen = 0;
    int valid_seen = 0;
    cfg_window   = 16'd0;
    gps_rec_mag  = 1'b1;
    gps_rec_sign = 1'b1;
    sample_en    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (stats_ready) ready_seen++;
      if (sample_valid) valid_seen++;
    end
    sample_en = 1'b0;
    tick();
    if (stats_ready) ready_seen++;
    vectors++;
    if (ready_seen != 0) begin
      miscompares++;
      $display("FAIL disabled_ready got %0d pulses expected 0", ready_seen);
    end
    vectors++;
    if (valid_seen != 100 || sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_valid got %0d pulses (last=%b) expected 100 (last=0)", valid_seen, sample_valid);
    end
  endtask

  task automatic test_reset_mid_window();
    logic [WIN_W*2+6-1:0] got;
    cfg_window = 16'd8;
    for (int i = 0; i < 5; i++) feed_sample(1'b1, 1'b1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    got = {sample_sign, sample_mag, sample_valid, mag_count, sign_count, stats_ready, agc_high, agc_low};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got=%h expected=0", got);
    end
    run_window(16'h00FF, 16'h0000, 8, "reset_mid_fresh");
    vectors++;
    if (mag_count !== 16'd8 || sign_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid_counts got mag=%0d sign=%0d expected mag=8 sign=0", mag_count, sign_count);
    end
  endtask

`ifdef NAMURU_FE_TESTGEN_EN
  task automatic test_testgen();
    logic [5:0] exp_pat;
    exp_pat = 6'b10_01_00;
    apply_reset();
    cfg_window = 16'd0;
    test_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed_sample(1'b0, 1'b1);
      vectors++;
      if ({sample_sign, sample_mag} !== exp_pat[5-2*i -: 2]) begin
        miscompares++;
        $display("FAIL testgen strobe %0d got s/m=%b%b expected %b", i, sample_sign, sample_mag, exp_pat[5-2*i -: 2]);
      end
    end
    test_en = 1'b0;
    feed_sample(1'b0, 1'b1);
    vectors++;
    if ({sample_sign, sample_mag} !== 2'b01) begin
      miscompares++;
      $display("FAIL testgen_off got s/m=%b%b expected 01", sample_sign, sample_mag);
    end
  endtask
`endif

  initial begin
    sys_rst      = 1'b1;
    gps_rec_sign = 1'b0;
    gps_rec_mag  = 1'b0;
    sample_en    = 1'b0;
    cfg_window   = '0;
    cfg_agc_hi   = '0;
    cfg_agc_lo   = '0;
`ifdef NAMURU_FE_TESTGEN_EN
    test_en      = 1'b0;
`endif
    test_reset();
    test_single_sample();
    test_latency();
    test_stats_agc();
    test_window_change();
    test_disabled();
    test_reset_mid_window();
`ifdef NAMURU_FE_TESTGEN_EN
    test_testgen();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
